lsu_mw: RTL

- Load/store unit in the memory/writeback stage, directly downstream of the execute-to-MW pipeline register.
- Consumes the registered ALU result (effective address), store data and destination register.
- Runs a req/gnt/rvalid handshake with data memory, formats load data (size and sign), and produces the stall that freezes the MW register while an access is outstanding.

---
 rtl/lsu_mw.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mw.sv
// lsu_mw: memory/writeback-stage load/store unit.
// Runs the req/gnt/rvalid data-memory handshake and formats load results.
module lsu_mw #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_mw,
    input  logic        mem_write_mw,
    input  logic [2:0]  funct3_mw,
    input  logic [31:0] addr_mw,
    input  logic [31:0] wdata_mw,
    input  logic [4:0]  waddr_mw,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_strb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mw,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  load_waddr,
    output logic        misaligned,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;
    logic [4:0]    waddr_q;
    logic          op;
    logic          bad_f3;
    logic          bad_align;
    logic          go;
    logic          cpl;
    logic          tmo;
    logic          tmo_hit;
    logic [3:0]    strb_d;
    logic [31:0]   wdata_d;
    logic [31:0]   rsh;
    logic [31:0]   fmt;

    always_comb begin
        op        = mem_read_mw | mem_write_mw;
        bad_f3    = 1'b0;
        bad_align = 1'b0;
        strb_d    = 4'b0000;
        wdata_d   = wdata_mw;
        unique case (funct3_mw)
            3'b000: begin
                strb_d  = 4'b0001 << addr_mw[1:0];
                wdata_d = {4{wdata_mw[7:0]}};
            end
            3'b001: begin
                bad_align = addr_mw[0];
                strb_d    = 4'b0011 << addr_mw[1:0];
                wdata_d   = {2{wdata_mw[15:0]}};
            end
            3'b010: begin
                bad_align = |addr_mw[1:0];
                strb_d    = 4'b1111;
            end
            3'b100: bad_f3 = mem_write_mw;
            3'b101: begin
                bad_align = addr_mw[0];
                bad_f3    = mem_write_mw;
            end
            default: bad_f3 = 1'b1;
        endcase
        if (!mem_write_mw) strb_d = 4'b0000;
    end

    assign go      = op & ~bad_f3 & ~bad_align;
    assign tmo_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (go) nxt = REQ;
            REQ: begin
                if (cpl | tmo)   nxt = DONE;
                else if (dmem_gnt) nxt = WAIT;
            end
            WAIT: if (cpl | tmo) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = (state == REQ);
        stall_mw   = 1'b0;
        misaligned = 1'b0;
        cpl        = 1'b0;
        tmo        = 1'b0;
        unique case (state)
            IDLE: begin
                stall_mw   = go;
                misaligned = op & ~go;
            end
            REQ: begin
                stall_mw = 1'b1;
                cpl      = dmem_gnt & dmem_rvalid;
                tmo      = tmo_hit & ~cpl;
            end
            WAIT: begin
                stall_mw = 1'b1;
                cpl      = dmem_rvalid;
                tmo      = tmo_hit & ~cpl;
            end
            default: ;
        endcase
    end

    always_comb begin
        rsh = dmem_rdata >> {lane_q, 3'b000};
        unique case (f3_q)
            3'b000:  fmt = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  fmt = {{16{rsh[15]}}, rsh[15:0]};
            3'b100:  fmt = {24'b0, rsh[7:0]};
            3'b101:  fmt = {16'b0, rsh[15:0]};
            default: fmt = rsh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Load data is formatted from rdata on the rvalid edge, shown in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_strb  <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
            waddr_q    <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
            load_waddr <= '0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            if (state == IDLE && go) begin
                dmem_we    <= mem_write_mw;
                dmem_addr  <= {addr_mw[31:2], 2'b00};
                dmem_wdata <= wdata_d;
                dmem_strb  <= strb_d;
                lane_q     <= addr_mw[1:0];
                f3_q       <= funct3_mw;
                waddr_q    <= waddr_mw;
            end
            if (cpl) begin
                if (!dmem_we) begin
                    load_valid <= 1'b1;
                    load_data  <= fmt;
                    load_waddr <= waddr_q;
                end
            end else if (tmo) begin
                bus_err   <= 1'b1;
                load_data <= '0;
            end
        end
    end
endmodule
